// File: rtl/speck_ti_sequencer_if.sv
// Host and core signal bundle for the three-share Speck-128/128 TI sequencer.
// The sequencer uses the slave modport. The host/core side uses the master modport.
interface speck_ti_sequencer_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt_sh0;
  logic [127:0] pt_sh1;
  logic [127:0] pt_sh2;
  logic [127:0] key_sh0;
  logic [127:0] key_sh1;
  logic [127:0] key_sh2;
  logic [1:0]   rnd_in;
  logic         abort;
  logic         core_we;
  logic         core_start;
  logic [2:0]   core_din;
  logic [2:0]   core_kdin;
  logic [2:0]   core_carry_init;
  logic [1:0]   core_cipher0;
  logic [1:0]   core_cipher1;
  logic [1:0]   core_cipher2;
  logic         core_rndlessthan32;
  logic [127:0] ct_sh0;
  logic [127:0] ct_sh1;
  logic [127:0] ct_sh2;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         timeout_err;

  modport slave (
    input  in_valid, pt_sh0, pt_sh1, pt_sh2, key_sh0, key_sh1, key_sh2,
           rnd_in, abort, core_cipher0, core_cipher1, core_cipher2,
           core_rndlessthan32, out_ready,
    output in_ready, core_we, core_start, core_din, core_kdin, core_carry_init,
           ct_sh0, ct_sh1, ct_sh2, out_valid, busy, timeout_err
  );

  modport master (
    output in_valid, pt_sh0, pt_sh1, pt_sh2, key_sh0, key_sh1, key_sh2,
           rnd_in, abort, core_cipher0, core_cipher1, core_cipher2,
           core_rndlessthan32, out_ready,
    input  in_ready, core_we, core_start, core_din, core_kdin, core_carry_init,
           ct_sh0, ct_sh1, ct_sh2, out_valid, busy, timeout_err
  );
endinterface

// File: rtl/speck_ti_sequencer.sv
// Sequencer that serially loads three plaintext/key shares into the bit-serial Speck TI core,
// supervises the run, and collects the three ciphertext shares. The shares are never combined.
module speck_ti_sequencer #(
  parameter int WATCHDOG_CYCLES = 2112,
  parameter int LOAD_BITS       = 128,
  parameter int UNLOAD_CYCLES   = 64
) (
  input logic clk,
  input logic rst,
  speck_ti_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_UNLOAD,
    S_DONE
  } state_t;

  localparam int WDW = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [6:0]     LAST_BIT    = 7'(LOAD_BITS - 1);
  localparam logic [5:0]     LAST_UNLOAD = 6'(UNLOAD_CYCLES - 1);
  localparam logic [WDW-1:0] WD_LAST     = WDW'(WATCHDOG_CYCLES - 1);

  state_t         r_state;
  logic [127:0]   r_pt0, r_pt1, r_pt2;
  logic [127:0]   r_key0, r_key1, r_key2;
  logic [127:0]   r_ct0, r_ct1, r_ct2;
  logic [6:0]     r_bitcnt;
  logic [5:0]     r_ucnt;
  logic [WDW-1:0] r_wdcnt;
  logic           r_we;
  logic           r_start;
  logic [2:0]     r_din;
  logic [2:0]     r_kdin;
  logic           r_out_valid;
  logic           r_timeout;

  // The carry masks are three shares of zero built from the two fresh random bits.
  assign bus.core_carry_init = {bus.rnd_in[0], bus.rnd_in[1], bus.rnd_in[0] ^ bus.rnd_in[1]};
  assign bus.in_ready        = (r_state == S_IDLE);
  assign bus.busy            = (r_state != S_IDLE);
  assign bus.core_we         = r_we;
  assign bus.core_start      = r_start;
  assign bus.core_din        = r_din;
  assign bus.core_kdin       = r_kdin;
  assign bus.ct_sh0          = r_ct0;
  assign bus.ct_sh1          = r_ct1;
  assign bus.ct_sh2          = r_ct2;
  assign bus.out_valid       = r_out_valid;
  assign bus.timeout_err     = r_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pt0       <= '0;
      r_pt1       <= '0;
      r_pt2       <= '0;
      r_key0      <= '0;
      r_key1      <= '0;
      r_key2      <= '0;
      r_ct0       <= '0;
      r_ct1       <= '0;
      r_ct2       <= '0;
      r_bitcnt    <= '0;
      r_ucnt      <= '0;
      r_wdcnt     <= '0;
      r_we        <= 1'b0;
      r_start     <= 1'b0;
      r_din       <= '0;
      r_kdin      <= '0;
      r_out_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else if (bus.abort && r_state != S_IDLE) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_start     <= 1'b0;
      r_din       <= '0;
      r_kdin      <= '0;
      r_out_valid <= 1'b0;
      r_bitcnt    <= '0;
      r_ucnt      <= '0;
      r_wdcnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            // Bit 0 goes straight to the core outputs so the first LOAD cycle already carries it.
            r_din     <= {bus.pt_sh2[0], bus.pt_sh1[0], bus.pt_sh0[0]};
            r_kdin    <= {bus.key_sh2[0], bus.key_sh1[0], bus.key_sh0[0]};
            r_pt0     <= bus.pt_sh0 >> 1;
            r_pt1     <= bus.pt_sh1 >> 1;
            r_pt2     <= bus.pt_sh2 >> 1;
            r_key0    <= bus.key_sh0 >> 1;
            r_key1    <= bus.key_sh1 >> 1;
            r_key2    <= bus.key_sh2 >> 1;
            r_we      <= 1'b1;
            r_bitcnt  <= '0;
            r_timeout <= 1'b0;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_bitcnt <= r_bitcnt + 7'd1;
          if (r_bitcnt == LAST_BIT) begin
            r_we    <= 1'b0;
            r_start <= 1'b1;
            r_din   <= '0;
            r_kdin  <= '0;
            r_wdcnt <= '0;
            r_state <= S_RUN;
          end else begin
            r_din  <= {r_pt2[0], r_pt1[0], r_pt0[0]};
            r_kdin <= {r_key2[0], r_key1[0], r_key0[0]};
            r_pt0  <= r_pt0 >> 1;
            r_pt1  <= r_pt1 >> 1;
            r_pt2  <= r_pt2 >> 1;
            r_key0 <= r_key0 >> 1;
            r_key1 <= r_key1 >> 1;
            r_key2 <= r_key2 >> 1;
          end
        end
        S_RUN: begin
          r_wdcnt <= r_wdcnt + 1'b1;
          if (r_wdcnt == WD_LAST) begin
            r_timeout <= 1'b1;
            r_start   <= 1'b0;
            r_state   <= S_IDLE;
          end else if (!bus.core_rndlessthan32) begin
            r_ucnt  <= '0;
            r_state <= S_UNLOAD;
          end
        end
        S_UNLOAD: begin
          // x-half takes cipher bit 1, y-half cipher bit 0; both shift right so sample 0 lands in bit 0.
          r_ct0  <= {bus.core_cipher0[1], r_ct0[127:65], bus.core_cipher0[0], r_ct0[63:1]};
          r_ct1  <= {bus.core_cipher1[1], r_ct1[127:65], bus.core_cipher1[0], r_ct1[63:1]};
          r_ct2  <= {bus.core_cipher2[1], r_ct2[127:65], bus.core_cipher2[0], r_ct2[63:1]};
          r_ucnt <= r_ucnt + 6'd1;
          if (r_ucnt == LAST_UNLOAD) begin
            r_start     <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
